// File: rtl/csr_encoder_if.sv
// Element stream into the CSR encoder: start pulse plus a valid/ready data handshake.
interface csr_encoder_if;
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_data;

    modport master (output start, output in_valid, output in_data, input in_ready);
    modport slave  (input start, input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/csr_encoder.sv
// Builds CSR arrays (val/col/rowPtr) from a row-major dense matrix stream.
// Zero elements are dropped; non-zeros beyond capacity raise a sticky overflow.
module csr_encoder #(
    parameter int n   = 10,
    parameter int m   = 4,
    parameter int nnz = 16
) (
    input  logic               clk,
    input  logic               rst,
    csr_encoder_if.slave       in_if,
    output logic signed [31:0] val_o       [nnz],
    output logic        [31:0] col_o       [nnz],
    output logic        [31:0] rowPtr_o    [n+1],
    output logic        [31:0] nnz_count_o,
    output logic               done_o,
    output logic               overflow_o
);
    localparam int VW = $clog2(nnz);
    localparam int RW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    state_e             state_q, state_d;
    logic signed [31:0] val_q [nnz], val_d [nnz];
    logic        [31:0] col_q [nnz], col_d [nnz];
    logic        [31:0] rp_q  [n+1], rp_d  [n+1];
    logic        [31:0] cnt_q, cnt_d, r_q, r_d, c_q, c_d;
    logic        [31:0] cnt_acc;
    logic               ovf_q, ovf_d;
    logic [VW-1:0]      vidx;
    logic [RW-1:0]      ridx;

    always_comb begin
        state_d        = state_q;
        val_d          = val_q;
        col_d          = col_q;
        rp_d           = rp_q;
        cnt_d          = cnt_q;
        r_d            = r_q;
        c_d            = c_q;
        ovf_d          = ovf_q;
        cnt_acc        = cnt_q;
        vidx           = cnt_q[VW-1:0];
        ridx           = RW'(r_q + 32'd1);
        in_if.in_ready = 1'b0;
        done_o         = (state_q == DONE);

        unique case (state_q)
            IDLE, DONE: begin
                if (in_if.start) begin
                    state_d = LOAD;
                    val_d   = '{default: '0};
                    col_d   = '{default: '0};
                    rp_d    = '{default: '0};
                    cnt_d   = '0;
                    r_d     = '0;
                    c_d     = '0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                in_if.in_ready = 1'b1;
                if (in_if.in_valid) begin
                    if (in_if.in_data != 0) begin
                        if (cnt_q < nnz) begin
                            val_d[vidx] = in_if.in_data;
                            col_d[vidx] = c_q;
                            cnt_acc     = cnt_q + 32'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    cnt_d = cnt_acc;
                    // Row pointer includes the element accepted on this same edge.
                    if (c_q == m - 1) begin
                        rp_d[ridx] = cnt_acc;
                        c_d        = '0;
                        r_d        = r_q + 32'd1;
                        if (r_q == n - 1) state_d = DONE;
                    end else begin
                        c_d = c_q + 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            val_q   <= '{default: '0};
            col_q   <= '{default: '0};
            rp_q    <= '{default: '0};
            cnt_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            col_q   <= col_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign val_o       = val_q;
    assign col_o       = col_q;
    assign rowPtr_o    = rp_q;
    assign nnz_count_o = cnt_q;
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_csr_encoder.sv
// Bench for csr_encoder: directed vector table plus randomized loads against a queue-based CSR model.
module tb_csr_encoder;
    localparam int N   = 10;
    localparam int M   = 4;
    localparam int NNZ = 16;
    localparam int E   = N * M;

    typedef logic [E-1:0][31:0] mat_t;
    typedef struct packed {
        logic [NNZ-1:0][31:0] v;
        logic [NNZ-1:0][31:0] c;
        logic [N:0][31:0]     rp;
        logic [31:0]          cnt;
        logic                 ovf;
    } exp_t;
    typedef struct packed {
        mat_t        mat;
        logic [1:0]  mode;
        logic [31:0] lat_min;
        logic [31:0] lat_max;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_encoder_if bus();
    logic signed [31:0] val [NNZ];
    logic        [31:0] col [NNZ];
    logic        [31:0] rp  [N+1];
    logic        [31:0] cnt;
    logic               done, ovf;

    csr_encoder #(.n(N), .m(M), .nnz(NNZ)) dut (
        .clk(clk), .rst(rst), .in_if(bus),
        .val_o(val), .col_o(col), .rowPtr_o(rp),
        .nnz_count_o(cnt), .done_o(done), .overflow_o(ovf)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d exp=%0d", nm, idx, $signed(act), $signed(exp));
        end
    endtask

    task automatic check_arrays(input string tag, input exp_t e, input logic exp_done);
        for (int i = 0; i < NNZ; i++) begin
            chk({tag, ".val"}, i, val[i], e.v[i]);
            chk({tag, ".col"}, i, col[i], e.c[i]);
        end
        for (int i = 0; i <= N; i++) chk({tag, ".rowPtr"}, i, rp[i], e.rp[i]);
        chk({tag, ".nnz_count"}, 0, cnt, e.cnt);
        chk({tag, ".overflow"}, 0, 32'(ovf), 32'(e.ovf));
        chk({tag, ".done"}, 0, 32'(done), 32'(exp_done));
    endtask

    // CSR reference: walk rows, keep non-zeros in a queue, saturate pointers at capacity.
    function automatic exp_t model(input mat_t mt);
        exp_t x = '0;
        int qv[$];
        int qc[$];
        int total = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < M; c++) begin
                if (mt[r*M + c] != 0) begin
                    total++;
                    if (qv.size() < NNZ) begin
                        qv.push_back(int'(mt[r*M + c]));
                        qc.push_back(c);
                    end
                end
            end
            x.rp[r+1] = (total < NNZ) ? total : NNZ;
        end
        for (int i = 0; i < qv.size(); i++) begin
            x.v[i] = qv[i];
            x.c[i] = qc[i];
        end
        x.cnt = qv.size();
        x.ovf = (total > NNZ);
        return x;
    endfunction

    // mode 0: valid always high; 1: alternating; 2: random stalls.
    task automatic run_load(input string tag, input mat_t mt, input int mode, output int cycles);
        int k = 0;
        logic v;
        logic phase = 1'b1;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; cycles = 1;
        chk({tag, ".ready_after_start"}, 0, 32'(bus.in_ready), 32'd1);
        chk({tag, ".done_low_in_load"}, 0, 32'(done), 32'd0);
        while (!done && cycles < 1000) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = phase; phase = ~phase; end
                default: v = ($urandom_range(99) < 60);
            endcase
            if (k >= E) v = 1'b0;
            bus.in_valid = v;
            bus.in_data  = v ? mt[k] : $urandom;
            @(negedge clk); cycles++;
            if (v && k < E) k++;
        end
        bus.in_valid = 1'b0;
        chk({tag, ".done_seen"}, 0, 32'(done), 32'd1);
        chk({tag, ".ready_in_done"}, 0, 32'(bus.in_ready), 32'd0);
        chk({tag, ".accepts"}, 0, k, E);
    endtask

    vec_t vecs[4];
    mat_t scen2;
    mat_t rm;
    int   lat;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Vector table: one-per-row, all-zero, overflow, backpressure.
        scen2 = '0;
        for (int i = 0; i < N; i++) scen2[i*M + i%M] = i + 1;
        for (int t = 0; t < 4; t++) vecs[t] = '0;
        vecs[0].mat = scen2; vecs[0].mode = 0; vecs[0].lat_min = 41; vecs[0].lat_max = 41;
        for (int i = 0; i < 10; i++) begin
            vecs[0].e.v[i] = i + 1;
            vecs[0].e.c[i] = i % 4;
        end
        for (int i = 0; i <= 10; i++) vecs[0].e.rp[i] = i;
        vecs[0].e.cnt = 10;

        vecs[1].mode = 0; vecs[1].lat_min = 41; vecs[1].lat_max = 41;

        for (int i = 0; i < 16; i++) vecs[2].mat[i] = i + 1;
        for (int i = 16; i < 20; i++) vecs[2].mat[i] = -(i + 1);
        vecs[2].mode = 0; vecs[2].lat_min = 41; vecs[2].lat_max = 41;
        for (int i = 0; i < 16; i++) begin
            vecs[2].e.v[i] = i + 1;
            vecs[2].e.c[i] = i % 4;
        end
        vecs[2].e.rp[0] = 0; vecs[2].e.rp[1] = 4; vecs[2].e.rp[2] = 8; vecs[2].e.rp[3] = 12;
        for (int i = 4; i <= 10; i++) vecs[2].e.rp[i] = 16;
        vecs[2].e.cnt = 16; vecs[2].e.ovf = 1'b1;

        vecs[3]      = vecs[0];
        vecs[3].mode = 1; vecs[3].lat_min = 78; vecs[3].lat_max = 82;

        // Reset held: start must be ignored.
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        check_arrays("reset_hold", '0, 1'b0);
        chk("reset_hold.ready", 0, 32'(bus.in_ready), 32'd0);
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        chk("post_reset.ready", 0, 32'(bus.in_ready), 32'd0);

        for (int t = 0; t < 4; t++) begin
            run_load($sformatf("vec%0d", t), vecs[t].mat, int'(vecs[t].mode), lat);
            checks++;
            if (lat < int'(vecs[t].lat_min) || lat > int'(vecs[t].lat_max)) begin
                failures++;
                $display("FAIL vec%0d.latency got=%0d exp=%0d..%0d", t, lat, vecs[t].lat_min, vecs[t].lat_max);
            end
            check_arrays($sformatf("vec%0d", t), vecs[t].e, 1'b1);
        end

        // Second start while in DONE: full clear and done drops next cycle.
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check_arrays("restart", '0, 1'b0);
        chk("restart.ready", 0, 32'(bus.in_ready), 32'd1);

        // Asynchronous reset mid-load after 17 accepts, then reload.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = scen2[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("partial.nnz_count", 0, cnt, 32'd5);
        #2 rst = 1'b1;
        #1;
        check_arrays("midload_reset", '0, 1'b0);
        chk("midload_reset.ready", 0, 32'(bus.in_ready), 32'd0);
        @(negedge clk); rst = 1'b0;
        run_load("reload", scen2, 0, lat);
        chk("reload.latency", 0, lat, 41);
        check_arrays("reload", vecs[0].e, 1'b1);

        // Random matrices with random density and stalls.
        for (int it = 0; it < 20; it++) begin
            int dens;
            dens = $urandom_range(70);
            for (int i = 0; i < E; i++)
                rm[i] = ($urandom_range(99) < dens) ? $urandom_range(2000) - 1000 : 0;
            run_load($sformatf("rand%0d", it), rm, int'($urandom_range(2)), lat);
            checks++;
            if (lat < 41) begin
                failures++;
                $display("FAIL rand%0d.latency got=%0d exp>=41", it, lat);
            end
            check_arrays($sformatf("rand%0d", it), model(rm), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
